ps2_key_event: RTL
==================

// Module: ps2_key_event
// PURPOSE
//  Scan-code decoder between ps2_keyboard (byte FIFO, ready/nextdata_n) and display/CPU consumers.
//  Pops bytes and resolves set-2 prefixes (E0 extended, F0 break) into one event per key action.
//  Tracks shift, filters typematic repeats, maps codes to ASCII and counts presses.
//  Delivers events through a FIFO with a valid/ready interface.
// PARAMETERS
//  FIFO_DEPTH        8  event FIFO entries; power of two, >=2
//  CNT_W             8  width of press counter; wraps modulo 2**CNT_W
//  TYPEMATIC_FILTER  1  1: suppress repeated make of the currently held key; 0: pass repeats through
//  SHIFT_EN          1  1: shift state selects ASCII case/symbol; 0: shift ignored for ASCII
// PORTS
//  clk            in   1      system clock; every register updates on posedge
//  reset          in   1      synchronous active-high reset
//  kb_data        in   8      byte from ps2_keyboard
//  kb_ready       in   1      ps2_keyboard holds a byte
//  kb_overflow    in   1      ps2_keyboard FIFO overflowed (sampled into err_ovf)
//  kb_nextdata_n  out  1      active-low pop strobe to ps2_keyboard
//  ev_valid       out  1      event FIFO not empty
//  ev_ready       in   1      consumer pops the head event when ev_valid & ev_ready
//  ev_code        out  8      scan code of head event (prefixes stripped)
//  ev_ext         out  1      head event was E0-prefixed
//  ev_break       out  1      head event is a release
//  ev_ascii       out  8      ASCII of head event; 8'h00 if unmapped or ext
//  shift          out  1      left (12) or right (59) shift currently held
//  press_cnt      out  CNT_W  accepted make events since reset
//  err_drop       out  1      sticky: an event was lost because the FIFO was full
//  err_ovf        out  1      sticky: kb_overflow was seen high
// BEHAVIOUR
//  Reset: kb_nextdata_n=1, ev_valid=0, shift=0, press_cnt=0, err_drop=0, err_ovf=0.
//   FIFO is emptied, both FSMs go to idle, last_make is cleared. Reset mid-sequence discards partial prefixes.
//  Pop FSM: IDLE -(kb_ready)-> POP -> GAP -> IDLE.
//   On entry to POP: capture kb_data and drive kb_nextdata_n=0 for exactly one cycle.
//   GAP is one cycle with kb_nextdata_n=1; kb_ready is ignored. This lets ps2_keyboard update, so there is no double pop.
//   Throughput is at most 1 byte per 3 clk.
//  Prefix FSM: it advances once per captured byte. States are NORM, EXT, BRK and EXT_BRK.
//   NORM: E0->EXT; F0->BRK; other byte -> emit make{ext=0}.
//   EXT:  F0->EXT_BRK; E0->EXT; other byte -> emit make{ext=1}, then NORM.
//   BRK:  F0->BRK; E0->EXT_BRK; other byte -> emit break{ext=0}, then NORM.
//   EXT_BRK: E0/F0 -> stay; other byte -> emit break{ext=1}, then NORM.
//  Emit rules, applied in the cycle after capture:
//   make equal to last_make while TYPEMATIC_FILTER=1: suppressed; no push, no count.
//   any other make: last_make<={ext,code}; press_cnt+=1 (wraps); push.
//   break: if {ext,code}==last_make, clear last_make. Always push; no count.
//   non-ext 12/59: shift_l/shift_r set on make, cleared on break. The event is still pushed.
//  ASCII: A-Z codes give 61-7A, or 41-5A when shift&SHIFT_EN.
//   Digits 45,16,1E,26,25,2E,36,3D,3E,46 give 30-39 unshifted and )!@#$%^&*( shifted.
//   Space 29 gives 20. All else gives 00. ASCII is computed at push time from the shift value before that event.
//  Event FIFO: a push while full drops the new event and sets err_drop. A push and a pop in the same cycle when full succeeds.
//   ev_* come from the head register and are stable while ev_valid&~ev_ready.
//   Latency from capture to ev_valid on an empty FIFO is 2 clk.
//  err_ovf <= err_ovf | kb_overflow. Both error flags clear only on reset.
// STRUCTURE
//  Package ps2_pkg holds:
//   localparams PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_LSHIFT=8'h12, PS2_RSHIFT=8'h59, PS2_SPACE=8'h29;
//   pop-state and prefix-state encodings;
//   the event struct {ext,brk,code[7:0],ascii[7:0]}.
//  Sub-module ps2_ascii_lut (combinational: code, shift -> ascii).
//  FIFO is inline: pointers of width $clog2(FIFO_DEPTH)+1.
// TESTING
//  Bytes 1C,F0,1C, ev_ready=1 -> events {1C,make,61} then {1C,break,61}; press_cnt=1; kb_nextdata_n is low for one cycle per byte.
//  Bytes 12,1C,F0,1C,F0,12 -> 4 events; the 1C make has ascii 41; shift is 1 between them and 0 at end.
//  Bytes E0,75,E0,F0,75 -> {75,ext=1,make,00} then {75,ext=1,break,00}; press_cnt=1.
//  Bytes 1C,1C,1C,F0,1C with TYPEMATIC_FILTER=1 -> 2 events, press_cnt=1. With the filter at 0 -> 4 events, press_cnt=3.
//  ev_ready=0, FIFO_DEPTH=8, 10 makes of distinct keys -> 8 held; err_drop=1; head stays stable.
//   Then ev_ready=1 -> 8 pops in order.
//  Assert reset after E0,F0 with kb_ready high, then send 1C -> plain make of 1C; outputs are at reset values during reset.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and the event record for the PS/2 key event decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;
    localparam logic [7:0] PS2_SPACE  = 8'h29;

    typedef enum logic [1:0] {
        POP_IDLE = 2'd0,
        POP_CAP  = 2'd1,
        POP_GAP  = 2'd2
    } pop_state_t;

    typedef enum logic [1:0] {
        PFX_NORM    = 2'd0,
        PFX_EXT     = 2'd1,
        PFX_BRK     = 2'd2,
        PFX_EXT_BRK = 2'd3
    } pfx_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
        logic [7:0] ascii;
    } ps2_event_t;

    // Letters are stored lower case; shifting maps them onto the upper-case block.
    function automatic logic [7:0] ps2_letter(input logic [7:0] lower, input logic shifted);
        return shifted ? (lower - 8'h20) : lower;
    endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Set-2 scan code to ASCII for letters, digit row and space; everything else maps to 00.
module ps2_ascii_lut
    import ps2_pkg::*;
(
    input  logic [7:0] i_code,
    input  logic       i_shift,
    output logic [7:0] o_ascii
);

    always_comb begin
        o_ascii = 8'h00;
        case (i_code)
            8'h1C: o_ascii = ps2_letter(8'h61, i_shift);
            8'h32: o_ascii = ps2_letter(8'h62, i_shift);
            8'h21: o_ascii = ps2_letter(8'h63, i_shift);
            8'h23: o_ascii = ps2_letter(8'h64, i_shift);
            8'h24: o_ascii = ps2_letter(8'h65, i_shift);
            8'h2B: o_ascii = ps2_letter(8'h66, i_shift);
            8'h34: o_ascii = ps2_letter(8'h67, i_shift);
            8'h33: o_ascii = ps2_letter(8'h68, i_shift);
            8'h43: o_ascii = ps2_letter(8'h69, i_shift);
            8'h3B: o_ascii = ps2_letter(8'h6A, i_shift);
            8'h42: o_ascii = ps2_letter(8'h6B, i_shift);
            8'h4B: o_ascii = ps2_letter(8'h6C, i_shift);
            8'h3A: o_ascii = ps2_letter(8'h6D, i_shift);
            8'h31: o_ascii = ps2_letter(8'h6E, i_shift);
            8'h44: o_ascii = ps2_letter(8'h6F, i_shift);
            8'h4D: o_ascii = ps2_letter(8'h70, i_shift);
            8'h15: o_ascii = ps2_letter(8'h71, i_shift);
            8'h2D: o_ascii = ps2_letter(8'h72, i_shift);
            8'h1B: o_ascii = ps2_letter(8'h73, i_shift);
            8'h2C: o_ascii = ps2_letter(8'h74, i_shift);
            8'h3C: o_ascii = ps2_letter(8'h75, i_shift);
            8'h2A: o_ascii = ps2_letter(8'h76, i_shift);
            8'h1D: o_ascii = ps2_letter(8'h77, i_shift);
            8'h22: o_ascii = ps2_letter(8'h78, i_shift);
            8'h35: o_ascii = ps2_letter(8'h79, i_shift);
            8'h1A: o_ascii = ps2_letter(8'h7A, i_shift);
            // Digit row: US layout symbols when shifted.
            8'h45: o_ascii = i_shift ? 8'h29 : 8'h30;
            8'h16: o_ascii = i_shift ? 8'h21 : 8'h31;
            8'h1E: o_ascii = i_shift ? 8'h40 : 8'h32;
            8'h26: o_ascii = i_shift ? 8'h23 : 8'h33;
            8'h25: o_ascii = i_shift ? 8'h24 : 8'h34;
            8'h2E: o_ascii = i_shift ? 8'h25 : 8'h35;
            8'h36: o_ascii = i_shift ? 8'h5E : 8'h36;
            8'h3D: o_ascii = i_shift ? 8'h26 : 8'h37;
            8'h3E: o_ascii = i_shift ? 8'h2A : 8'h38;
            8'h46: o_ascii = i_shift ? 8'h28 : 8'h39;
            PS2_SPACE: o_ascii = 8'h20;
            default: o_ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_key_event.sv
// Pops bytes from ps2_keyboard, folds E0/F0 prefixes into key events and queues them for a consumer.
//  pop state   | meaning
//  POP_IDLE    | waiting for kb_ready
//  POP_CAP     | byte captured, pop strobe low this cycle
//  POP_GAP     | one dead cycle so the keyboard FIFO can update
//  pfx state   | meaning
//  PFX_NORM    | no prefix pending
//  PFX_EXT     | E0 seen
//  PFX_BRK     | F0 seen
//  PFX_EXT_BRK | E0 and F0 seen
module ps2_key_event
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH       = 8,
    parameter int CNT_W            = 8,
    parameter bit TYPEMATIC_FILTER = 1'b1,
    parameter bit SHIFT_EN         = 1'b1
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       kb_data,
    input  logic             kb_ready,
    input  logic             kb_overflow,
    output logic             kb_nextdata_n,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic [7:0]       ev_ascii,
    output logic             shift,
    output logic [CNT_W-1:0] press_cnt,
    output logic             err_drop,
    output logic             err_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);

    pop_state_t       r_pop_state;
    logic [7:0]       r_byte;
    logic             r_byte_vld;

    pfx_state_t       r_pfx_state;
    ps2_event_t       r_emit;
    logic             r_emit_vld;
    logic [8:0]       r_last_make;
    logic             r_last_vld;
    logic             r_shift_l;
    logic             r_shift_r;
    logic [CNT_W-1:0] r_press_cnt;

    ps2_event_t       r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_err_drop;
    logic             r_err_ovf;

    logic             w_is_pfx;
    logic             w_ext;
    logic             w_brk;
    logic [8:0]       w_key;
    logic             w_repeat;
    logic [7:0]       w_lut_ascii;
    logic [7:0]       w_ascii;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    ps2_event_t       w_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pop_state   <= POP_IDLE;
            r_byte        <= 8'h00;
            r_byte_vld    <= 1'b0;
            kb_nextdata_n <= 1'b1;
        end else begin
            r_byte_vld <= 1'b0;
            case (r_pop_state)
                POP_IDLE: begin
                    if (kb_ready) begin
                        r_pop_state   <= POP_CAP;
                        r_byte        <= kb_data;
                        r_byte_vld    <= 1'b1;
                        kb_nextdata_n <= 1'b0;
                    end
                end
                POP_CAP: begin
                    r_pop_state   <= POP_GAP;
                    kb_nextdata_n <= 1'b1;
                end
                POP_GAP:  r_pop_state <= POP_IDLE;
                default:  r_pop_state <= POP_IDLE;
            endcase
        end
    end

    assign w_is_pfx = (r_byte == PS2_EXT) || (r_byte == PS2_BRK);
    assign w_ext    = (r_pfx_state == PFX_EXT) || (r_pfx_state == PFX_EXT_BRK);
    assign w_brk    = (r_pfx_state == PFX_BRK) || (r_pfx_state == PFX_EXT_BRK);
    assign w_key    = {w_ext, r_byte};
    assign w_repeat = TYPEMATIC_FILTER && r_last_vld && (r_last_make == w_key);
    assign w_ascii  = w_ext ? 8'h00 : w_lut_ascii;

    ps2_ascii_lut u_ascii_lut (
        .i_code  (r_byte),
        .i_shift (shift & SHIFT_EN),
        .o_ascii (w_lut_ascii)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pfx_state <= PFX_NORM;
            r_emit      <= '0;
            r_emit_vld  <= 1'b0;
            r_last_make <= 9'h000;
            r_last_vld  <= 1'b0;
            r_shift_l   <= 1'b0;
            r_shift_r   <= 1'b0;
            r_press_cnt <= '0;
        end else begin
            r_emit_vld <= 1'b0;
            if (r_byte_vld) begin
                case (r_pfx_state)
                    PFX_NORM: begin
                        if (r_byte == PS2_EXT)      r_pfx_state <= PFX_EXT;
                        else if (r_byte == PS2_BRK) r_pfx_state <= PFX_BRK;
                    end
                    PFX_EXT: begin
                        if (r_byte == PS2_BRK)      r_pfx_state <= PFX_EXT_BRK;
                        else if (!w_is_pfx)         r_pfx_state <= PFX_NORM;
                    end
                    PFX_BRK: begin
                        if (r_byte == PS2_EXT)      r_pfx_state <= PFX_EXT_BRK;
                        else if (!w_is_pfx)         r_pfx_state <= PFX_NORM;
                    end
                    PFX_EXT_BRK: begin
                        if (!w_is_pfx)              r_pfx_state <= PFX_NORM;
                    end
                    default: r_pfx_state <= PFX_NORM;
                endcase

                if (!w_is_pfx) begin
                    // ASCII uses the shift state from before this event is applied.
                    r_emit <= '{ext: w_ext, brk: w_brk, code: r_byte, ascii: w_ascii};
                    if (w_brk) begin
                        r_emit_vld <= 1'b1;
                        if (r_last_vld && (r_last_make == w_key)) r_last_vld <= 1'b0;
                        if (!w_ext && (r_byte == PS2_LSHIFT)) r_shift_l <= 1'b0;
                        if (!w_ext && (r_byte == PS2_RSHIFT)) r_shift_r <= 1'b0;
                    end else begin
                        if (!w_repeat) begin
                            r_emit_vld  <= 1'b1;
                            r_last_make <= w_key;
                            r_last_vld  <= 1'b1;
                            r_press_cnt <= r_press_cnt + CNT_W'(1);
                        end
                        if (!w_ext && (r_byte == PS2_LSHIFT)) r_shift_l <= 1'b1;
                        if (!w_ext && (r_byte == PS2_RSHIFT)) r_shift_r <= 1'b1;
                    end
                end
            end
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && ev_ready;
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign w_push  = r_emit_vld && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_err_drop <= 1'b0;
            r_err_ovf  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            if (r_emit_vld && !w_push) r_err_drop <= 1'b1;
            r_err_ovf <= r_err_ovf | kb_overflow;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_emit;
    end

    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign ev_valid  = !w_empty;
    assign ev_code   = w_head.code;
    assign ev_ext    = w_head.ext;
    assign ev_break  = w_head.brk;
    assign ev_ascii  = w_head.ascii;
    assign shift     = r_shift_l | r_shift_r;
    assign press_cnt = r_press_cnt;
    assign err_drop  = r_err_drop;
    assign err_ovf   = r_err_ovf;

endmodule
